// File: rtl/spi_slave_protocol_checker.sv
// rtl/spi_slave_protocol_checker.sv - SPI bus protocol checker and frame monitor
module spi_slave_protocol_checker #(
  parameter int NO_OF_SLAVES = 1,
  parameter int NO_OF_LANES  = 1,
  parameter int CHAR_LENGTH  = 8,
  parameter bit CPOL         = 1'b0,
  parameter bit CPHA         = 1'b0,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                    pclk,
  input  logic                    areset,
  input  logic                    sclk,
  input  logic [NO_OF_SLAVES-1:0] cs,
  input  logic [NO_OF_LANES-1:0]  mosi,
  input  logic [NO_OF_LANES-1:0]  miso,
  input  logic                    clr_err,
  output logic                    frame_valid,
  output logic [CHAR_LENGTH-1:0]  mosi_word,
  output logic [CHAR_LENGTH-1:0]  miso_word,
  output logic [15:0]             frame_count,
  output logic                    err_idle_pol,
  output logic                    err_multi_cs,
  output logic                    err_unstable,
  output logic                    err_short_frame
);

  // Counter is wide enough for CHAR_LENGTH up to 32.
  localparam logic [5:0] CHAR_LEN  = 6'(CHAR_LENGTH);
  localparam logic [5:0] LANE_STEP = 6'(NO_OF_LANES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                   state;
  logic                     sclk_p;
  logic [NO_OF_LANES-1:0]   mosi_p;
  logic [NO_OF_LANES-1:0]   miso_p;
  logic [5:0]               bit_cnt;
  logic [CHAR_LENGTH-1:0]   mosi_sr;
  logic [CHAR_LENGTH-1:0]   miso_sr;

  logic                     cs_seen;
  logic                     cs_multi;
  logic                     one_low;
  logic                     all_high;
  logic                     sclk_toggle;
  logic                     lead_edge;
  logic                     trail_edge;
  logic                     sample_edge;
  logic                     word_done;
  logic [5:0]               cnt_base;
  logic [5:0]               cnt_next;
  logic [CHAR_LENGTH-1:0]   mosi_shift;
  logic [CHAR_LENGTH-1:0]   miso_shift;
  logic                     set_idle_pol;
  logic                     set_multi_cs;
  logic                     set_unstable;
  logic                     set_short;

  // Classify the chip-select vector: none, exactly one, or several low.
  always_comb begin
    cs_seen  = 1'b0;
    cs_multi = 1'b0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (!cs[i]) begin
        if (cs_seen) begin
          cs_multi = 1'b1;
        end
        cs_seen = 1'b1;
      end
    end
  end

  assign one_low  = cs_seen & ~cs_multi;
  assign all_high = ~cs_seen;

  // The leading edge moves sclk away from its idle level, the trailing edge back to it.
  assign sclk_toggle = sclk ^ sclk_p;
  assign lead_edge   = sclk_toggle & (sclk != CPOL);
  assign trail_edge  = sclk_toggle & (sclk == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;

  // A word completes the cycle after its last group was shifted in.
  assign word_done = (bit_cnt == CHAR_LEN);
  assign cnt_base  = word_done ? 6'd0 : bit_cnt;
  assign cnt_next  = sample_edge ? (cnt_base + LANE_STEP) : cnt_base;

  // MSB-first shifts groups in at the bottom; LSB-first feeds them in at the top.
  assign mosi_shift = MSB_FIRST ? CHAR_LENGTH'({mosi_sr, mosi})
                                : CHAR_LENGTH'({mosi, mosi_sr} >> NO_OF_LANES);
  assign miso_shift = MSB_FIRST ? CHAR_LENGTH'({miso_sr, miso})
                                : CHAR_LENGTH'({miso, miso_sr} >> NO_OF_LANES);

  // Error set conditions, evaluated on the current cycle and registered below.
  assign set_idle_pol = (state == IDLE) & one_low & (sclk != CPOL);
  assign set_multi_cs = cs_multi;
  assign set_unstable = (state == ACTIVE) & sample_edge &
                        ((mosi != mosi_p) | (miso != miso_p));
  assign set_short    = (state == ACTIVE) & all_high &
                        (cnt_next != 6'd0) & (cnt_next != CHAR_LEN);

  // Frame FSM, shift registers, word outputs and sticky error flags.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state           <= IDLE;
      sclk_p          <= CPOL;
      mosi_p          <= '0;
      miso_p          <= '0;
      bit_cnt         <= 6'd0;
      mosi_sr         <= '0;
      miso_sr         <= '0;
      frame_valid     <= 1'b0;
      mosi_word       <= '0;
      miso_word       <= '0;
      frame_count     <= 16'd0;
      err_idle_pol    <= 1'b0;
      err_multi_cs    <= 1'b0;
      err_unstable    <= 1'b0;
      err_short_frame <= 1'b0;
    end else begin
      sclk_p      <= sclk;
      mosi_p      <= mosi;
      miso_p      <= miso;
      frame_valid <= 1'b0;

      if (word_done) begin
        mosi_word   <= mosi_sr;
        miso_word   <= miso_sr;
        frame_valid <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end

      case (state)
        IDLE: begin
          // Only a pending completion can leave bit_cnt nonzero here.
          bit_cnt <= 6'd0;
          if (one_low) begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (sample_edge) begin
            mosi_sr <= mosi_shift;
            miso_sr <= miso_shift;
          end
          if (all_high) begin
            state <= IDLE;
            // Keep a word whose last edge arrived with cs rising; drop partial ones.
            bit_cnt <= (cnt_next == CHAR_LEN) ? cnt_next : 6'd0;
          end else begin
            bit_cnt <= cnt_next;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= 6'd0;
        end
      endcase

      err_idle_pol    <= set_idle_pol | (err_idle_pol    & ~clr_err);
      err_multi_cs    <= set_multi_cs | (err_multi_cs    & ~clr_err);
      err_unstable    <= set_unstable | (err_unstable    & ~clr_err);
      err_short_frame <= set_short    | (err_short_frame & ~clr_err);
    end
  end

endmodule

// File: tb/tb_spi_slave_protocol_checker.sv
// tb/tb_spi_slave_protocol_checker.sv - self-checking bench for spi_slave_protocol_checker
module tb_spi_slave_protocol_checker;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;
  logic areset;

  // u0: mode 0, 1 lane, 8 bits, MSB first, two slaves
  logic sclk0, mosi0, miso0, clr0;
  logic [1:0] cs0;
  logic fv0, ei0, em0, eu0, es0;
  logic [7:0] mw0, sw0;
  logic [15:0] fc0;

  // u1: CPOL=1, CPHA=0
  logic sclk1, cs1, mosi1, miso1, clr1;
  logic fv1, ei1, em1, eu1, es1;
  logic [7:0] mw1, sw1;
  logic [15:0] fc1;

  // u2: quad lanes, 32 bits
  logic sclk2, cs2, clr2;
  logic [3:0] mosi2, miso2;
  logic fv2, ei2, em2, eu2, es2;
  logic [31:0] mw2, sw2;
  logic [15:0] fc2;

  // u3: CPHA=1, 2 lanes, LSB first
  logic sclk3, cs3, clr3;
  logic [1:0] mosi3, miso3;
  logic fv3, ei3, em3, eu3, es3;
  logic [7:0] mw3, sw3;
  logic [15:0] fc3;

  spi_slave_protocol_checker #(.NO_OF_SLAVES(2)) u0 (
    .pclk(pclk), .areset(areset), .sclk(sclk0), .cs(cs0), .mosi(mosi0), .miso(miso0),
    .clr_err(clr0), .frame_valid(fv0), .mosi_word(mw0), .miso_word(sw0), .frame_count(fc0),
    .err_idle_pol(ei0), .err_multi_cs(em0), .err_unstable(eu0), .err_short_frame(es0));

  spi_slave_protocol_checker #(.CPOL(1'b1)) u1 (
    .pclk(pclk), .areset(areset), .sclk(sclk1), .cs(cs1), .mosi(mosi1), .miso(miso1),
    .clr_err(clr1), .frame_valid(fv1), .mosi_word(mw1), .miso_word(sw1), .frame_count(fc1),
    .err_idle_pol(ei1), .err_multi_cs(em1), .err_unstable(eu1), .err_short_frame(es1));

  spi_slave_protocol_checker #(.NO_OF_LANES(4), .CHAR_LENGTH(32)) u2 (
    .pclk(pclk), .areset(areset), .sclk(sclk2), .cs(cs2), .mosi(mosi2), .miso(miso2),
    .clr_err(clr2), .frame_valid(fv2), .mosi_word(mw2), .miso_word(sw2), .frame_count(fc2),
    .err_idle_pol(ei2), .err_multi_cs(em2), .err_unstable(eu2), .err_short_frame(es2));

  spi_slave_protocol_checker #(.NO_OF_LANES(2), .CPHA(1'b1), .MSB_FIRST(1'b0)) u3 (
    .pclk(pclk), .areset(areset), .sclk(sclk3), .cs(cs3), .mosi(mosi3), .miso(miso3),
    .clr_err(clr3), .frame_valid(fv3), .mosi_word(mw3), .miso_word(sw3), .frame_count(fc3),
    .err_idle_pol(ei3), .err_multi_cs(em3), .err_unstable(eu3), .err_short_frame(es3));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fv0_n = 0;
  int fv1_n = 0;
  int fv2_n = 0;
  int fv3_n = 0;
  int fv2_t [4];
  logic [31:0] fv2_mw [4];
  logic [31:0] fv2_sw [4];

  // Pulse monitor: counts frame_valid pulses and records quad-lane completions.
  always @(negedge pclk) begin
    cyc <= cyc + 1;
    if (fv0 === 1'b1) fv0_n <= fv0_n + 1;
    if (fv1 === 1'b1) fv1_n <= fv1_n + 1;
    if (fv3 === 1'b1) fv3_n <= fv3_n + 1;
    if (fv2 === 1'b1 && fv2_n < 4) begin
      fv2_t[fv2_n]  <= cyc;
      fv2_mw[fv2_n] <= mw2;
      fv2_sw[fv2_n] <= sw2;
      fv2_n <= fv2_n + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Mode-0 frame on u0 through slave 0; nbits < 8 makes a truncated frame.
  task automatic send0(input logic [7:0] mo, input logic [7:0] mi, input int nbits);
    cs0 = 2'b10;
    tick(2);
    for (int i = 0; i < nbits; i++) begin
      mosi0 = mo[7-i];
      miso0 = mi[7-i];
      tick(3);
      sclk0 = 1'b1;
      tick(3);
      sclk0 = 1'b0;
    end
    tick(3);
    cs0 = 2'b11;
    tick(3);
  endtask

  typedef struct {
    logic [7:0]  mo;
    logic [7:0]  mi;
    int          nbits;
    int          exp_pulses;
    logic [7:0]  exp_mw;
    logic [7:0]  exp_sw;
    logic [15:0] exp_fc;
    logic        exp_short;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int pre;
    logic [31:0] w2mo [2];
    logic [31:0] w2mi [2];
    logic [7:0] mo1;
    logic [7:0] mo3;
    logic [7:0] mi3;

    vecs[0] = '{8'hA5, 8'h3C, 8, 1, 8'hA5, 8'h3C, 16'd1, 1'b0};
    vecs[1] = '{8'h5A, 8'hC3, 8, 1, 8'h5A, 8'hC3, 16'd2, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 5, 0, 8'h5A, 8'hC3, 16'd2, 1'b1};
    vecs[3] = '{8'h00, 8'hFF, 8, 1, 8'h00, 8'hFF, 16'd3, 1'b0};
    w2mo[0] = 32'hDEADBEEF; w2mo[1] = 32'h12345678;
    w2mi[0] = 32'h0F1E2D3C; w2mi[1] = 32'hCAFEF00D;

    areset = 1'b0;
    sclk0 = 1'b0; cs0 = 2'b11; mosi0 = 1'b0; miso0 = 1'b0; clr0 = 1'b0;
    sclk1 = 1'b1; cs1 = 1'b1;  mosi1 = 1'b0; miso1 = 1'b0; clr1 = 1'b0;
    sclk2 = 1'b0; cs2 = 1'b1;  mosi2 = 4'h0; miso2 = 4'h0; clr2 = 1'b0;
    sclk3 = 1'b0; cs3 = 1'b1;  mosi3 = 2'b0; miso3 = 2'b0; clr3 = 1'b0;
    tick(2);
    check("reset_fv", {31'd0, fv0}, 32'd0);
    check("reset_words", {16'd0, mw0, sw0}, 32'd0);
    check("reset_count", {16'd0, fc0}, 32'd0);
    check("reset_flags", {28'd0, ei0, em0, eu0, es0}, 32'd0);
    areset = 1'b1;
    tick(2);

    // Table-driven mode-0 frames.
    for (int v = 0; v < 4; v++) begin
      pre = fv0_n;
      send0(vecs[v].mo, vecs[v].mi, vecs[v].nbits);
      check($sformatf("vec%0d_pulses", v), fv0_n - pre, vecs[v].exp_pulses);
      check($sformatf("vec%0d_mosi", v), {24'd0, mw0}, {24'd0, vecs[v].exp_mw});
      check($sformatf("vec%0d_miso", v), {24'd0, sw0}, {24'd0, vecs[v].exp_sw});
      check($sformatf("vec%0d_count", v), {16'd0, fc0}, {16'd0, vecs[v].exp_fc});
      check($sformatf("vec%0d_short", v), {31'd0, es0}, {31'd0, vecs[v].exp_short});
      check($sformatf("vec%0d_other_flags", v), {29'd0, ei0, em0, eu0}, 32'd0);
      clr0 = 1'b1; tick(1); clr0 = 1'b0; tick(1);
    end

    // Two chip selects low: flag set and no frame captured despite 8 sample edges.
    pre = fv0_n;
    cs0 = 2'b00;
    tick(2);
    check("multi_cs_set", {31'd0, em0}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      mosi0 = i[0];
      tick(3); sclk0 = 1'b1; tick(3); sclk0 = 1'b0;
    end
    tick(3); cs0 = 2'b11; tick(3);
    check("multi_cs_no_frame", fv0_n - pre, 0);
    check("multi_cs_count", {16'd0, fc0}, 32'd3);
    check("multi_cs_no_short", {31'd0, es0}, 32'd0);
    clr0 = 1'b1; tick(1); clr0 = 1'b0; tick(1);
    check("multi_cs_cleared", {31'd0, em0}, 32'd0);

    // CPOL=1: cs falls with sclk low.
    sclk1 = 1'b0; tick(2);
    cs1 = 1'b0; tick(2);
    check("idle_pol_set", {31'd0, ei1}, 32'd1);
    cs1 = 1'b1; tick(1); sclk1 = 1'b1; tick(2);
    clr1 = 1'b1; tick(1); clr1 = 1'b0; tick(1);
    check("idle_pol_cleared", {31'd0, ei1}, 32'd0);
    sclk1 = 1'b0; tick(2);
    cs1 = 1'b0; clr1 = 1'b1; tick(1); clr1 = 1'b0; tick(1);
    check("idle_pol_set_wins", {31'd0, ei1}, 32'd1);
    cs1 = 1'b1; tick(1); sclk1 = 1'b1; tick(2);
    check("idle_pol_no_short", {31'd0, es1}, 32'd0);
    clr1 = 1'b1; tick(1); clr1 = 1'b0; tick(1);
    // Clean mode-2 frame: sample on falling edge.
    mo1 = 8'h96;
    cs1 = 1'b0; tick(2);
    for (int i = 0; i < 8; i++) begin
      mosi1 = mo1[7-i];
      tick(3); sclk1 = 1'b0; tick(3); sclk1 = 1'b1;
    end
    tick(3); cs1 = 1'b1; tick(3);
    check("mode2_pulses", fv1_n, 1);
    check("mode2_mosi", {24'd0, mw1}, 32'h96);
    check("mode2_flags", {28'd0, ei1, em1, eu1, es1}, 32'd0);

    // Quad lanes, two back-to-back 32-bit words under one cs.
    cs2 = 1'b0; tick(2);
    for (int w = 0; w < 2; w++) begin
      for (int g = 0; g < 8; g++) begin
        mosi2 = 4'(w2mo[w] >> (28 - 4*g));
        miso2 = 4'(w2mi[w] >> (28 - 4*g));
        tick(3); sclk2 = 1'b1; tick(3); sclk2 = 1'b0;
      end
    end
    tick(3); cs2 = 1'b1; tick(3);
    check("quad_pulses", fv2_n, 2);
    check("quad_spacing", fv2_t[1] - fv2_t[0], 48);
    check("quad_mosi0", fv2_mw[0], 32'hDEADBEEF);
    check("quad_miso0", fv2_sw[0], 32'h0F1E2D3C);
    check("quad_mosi1", fv2_mw[1], 32'h12345678);
    check("quad_miso1", fv2_sw[1], 32'hCAFEF00D);
    check("quad_count", {16'd0, fc2}, 32'd2);
    check("quad_flags", {28'd0, ei2, em2, eu2, es2}, 32'd0);

    // Mode 1, LSB first, 2 lanes; final sample edge coincides with cs rising.
    mo3 = 8'hB4; mi3 = 8'h1E;
    cs3 = 1'b0; tick(2);
    for (int g = 0; g < 4; g++) begin
      sclk3 = 1'b1;
      mosi3 = 2'(mo3 >> (2*g));
      miso3 = 2'(mi3 >> (2*g));
      tick(3);
      if (g == 3) cs3 = 1'b1;
      sclk3 = 1'b0;
      tick(3);
    end
    tick(3);
    check("lsb_pulses", fv3_n, 1);
    check("lsb_mosi", {24'd0, mw3}, 32'hB4);
    check("lsb_miso", {24'd0, sw3}, 32'h1E);
    check("lsb_count", {16'd0, fc3}, 32'd1);
    check("lsb_flags", {28'd0, ei3, em3, eu3, es3}, 32'd0);

    // mosi0 changes on a sample edge, then reset mid-frame.
    mosi0 = 1'b0; miso0 = 1'b0;
    cs0 = 2'b10; tick(2);
    for (int i = 0; i < 4; i++) begin
      tick(3);
      sclk0 = 1'b1;
      if (i == 3) mosi0 = 1'b1;
      tick(3);
      sclk0 = 1'b0;
    end
    tick(2);
    check("unstable_set", {31'd0, eu0}, 32'd1);
    areset = 1'b0;
    tick(1);
    check("midreset_fv", {31'd0, fv0}, 32'd0);
    check("midreset_words", {16'd0, mw0, sw0}, 32'd0);
    check("midreset_count", {16'd0, fc0}, 32'd0);
    check("midreset_flags", {28'd0, ei0, em0, eu0, es0}, 32'd0);
    cs0 = 2'b11; sclk0 = 1'b0; mosi0 = 1'b0;
    tick(2);
    areset = 1'b1;
    tick(2);
    pre = fv0_n;
    send0(8'h5A, 8'h96, 8);
    check("post_reset_pulses", fv0_n - pre, 1);
    check("post_reset_mosi", {24'd0, mw0}, 32'h5A);
    check("post_reset_miso", {24'd0, sw0}, 32'h96);
    check("post_reset_count", {16'd0, fc0}, 32'd1);
    check("post_reset_flags", {28'd0, ei0, em0, eu0, es0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
